// File: rtl/seq_det_pkg.sv
// Shared types and default constants for the serial sequence scanner.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_SEQ_W   = 10;
    localparam int unsigned DEF_PAT_W   = 4;
    localparam logic [3:0]  DEF_PATTERN = 4'b1011;
    localparam int unsigned DEF_CNT_W   = 4;

endpackage

// File: rtl/seq_pattern_matcher.sv
// Sliding-window pattern matcher over a serial bit stream.
// Build option: SEQ_DET_OVERLAP_EN keeps the window after a hit (overlapping matches).
module seq_pattern_matcher
    import seq_det_pkg::*;
#(
    parameter int unsigned      PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic bit_in,
    input  logic bit_valid,
    output logic hit
);

    localparam int unsigned SEEN_W = $clog2(PAT_W);
    localparam logic [SEEN_W-1:0] SEEN_MAX = SEEN_W'(PAT_W - 1);

    logic [PAT_W-2:0]  history;
    logic [SEEN_W-1:0] seen;
    logic [PAT_W-1:0]  window;

    assign window = {history, bit_in};
    assign hit    = bit_valid && (seen >= SEEN_MAX) && (window == PATTERN);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            history <= '0;
            seen    <= '0;
        end else if (bit_valid) begin
            history <= window[PAT_W-2:0];
`ifdef SEQ_DET_OVERLAP_EN
            if (seen != SEEN_MAX)
                seen <= seen + 1'b1;
`else
            // Restarting the valid-bit count forces PAT_W fresh bits before the next hit.
            if (hit)
                seen <= '0;
            else if (seen != SEEN_MAX)
                seen <= seen + 1'b1;
`endif
        end
    end

endmodule

// File: rtl/seq_scan_detector.sv
// Latches a captured sequence on start and scans it MSB-first for a fixed pattern.
// Build option: SEQ_DET_OVERLAP_EN (handled in seq_pattern_matcher) allows overlapping hits.
module seq_scan_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned      SEQ_W   = DEF_SEQ_W,
    parameter int unsigned      PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    parameter int unsigned      CNT_W   = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [SEQ_W-1:0]           seq_in,
    output logic                       busy,
    output logic                       done,
    output logic                       match,
    output logic [CNT_W-1:0]           match_count,
    output logic [$clog2(SEQ_W+1)-1:0] bit_idx
);

    localparam int unsigned IDX_W = $clog2(SEQ_W + 1);

    state_t           state;
    logic [SEQ_W-1:0] sr;
    logic             accept;
    logic             hit;

    assign accept = (state == IDLE) && start;

    seq_pattern_matcher #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_matcher (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept),
        .bit_in    (sr[SEQ_W-1]),
        .bit_valid (state == SCAN),
        .hit       (hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sr          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            match       <= 1'b0;
            match_count <= '0;
            bit_idx     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done  <= 1'b0;
                    match <= 1'b0;
                    if (start) begin
                        sr          <= seq_in;
                        match_count <= '0;
                        bit_idx     <= '0;
                        busy        <= 1'b1;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    sr      <= sr << 1;
                    bit_idx <= bit_idx + 1'b1;
                    match   <= hit;
                    if (hit && (match_count != '1))
                        match_count <= match_count + 1'b1;
                    if (bit_idx == IDX_W'(SEQ_W - 1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    match <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    match <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_scan_detector.md
# seq_scan_detector

Serial pattern detector that sits directly downstream of the switch-capture register. On a start pulse it latches the captured 10-bit sequence and scans it MSB-first, one bit per clock. A 4-bit pattern is matched across the stream, and the block pulses on every hit, counts hits, and flags completion for the LED/seven-segment display stage.

## Interface
- SEQ_W, 10: width of the captured sequence; the number of bits scanned.
- PAT_W, 4: pattern length (2..SEQ_W).
- PATTERN, 4'b1011: target pattern. The MSB is the first bit expected in time.
- CNT_W, 4: match counter width.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  level-sampled request; accepted only in IDLE.
- seq_in  in  SEQ_W  captured sequence; sampled on the accepting edge only.
- busy  out  1  high while in SCAN.
- done  out  1  one-cycle pulse; the scan is complete and match_count is final.
- match  out  1  one-cycle pulse; the most recently consumed bit completed a pattern.
- match_count  out  CNT_W  number of hits in the current or last scan.
- bit_idx  out  $clog2(SEQ_W+1)  number of bits consumed so far.

## Operation
- The FSM has three states: IDLE, SCAN, DONE. All outputs are registered.
- IDLE to SCAN on `start`:
  - Load the shift register with seq_in.
  - Clear match_count, bit_idx, the history window and the seen-counter.
- SCAN, each edge:
  - Consume b = sr[SEQ_W-1]; shift sr left.
  - bit_idx += 1; history <= {history[PAT_W-2:0], b}.
- A hit is defined as: seen >= PAT_W-1 and {history[PAT_W-2:0], b} == PATTERN.
- On a hit, on the same edge:
  - match <= 1.
  - match_count += 1, saturating at 2^CNT_W-1.
- match is 0 on every other edge.
- seen counts valid history bits and saturates at PAT_W-1.
- SCAN to DONE on the edge that consumes bit SEQ_W-1. On that edge done <= 1 and busy <= 0.
- DONE to IDLE unconditionally on the next edge; done returns to 0.
- start is ignored in SCAN and DONE; there is no queuing.
- match_count and bit_idx hold their values in DONE and IDLE until the next accepted start.
- rst, from any state including mid-scan, takes effect on the next edge:
  - State returns to IDLE.
  - busy=0, done=0, match=0, match_count=0, bit_idx=0.
  - The shift register, history and seen are all cleared.
- rst has priority over start.

## Timing
- Let E0 be the edge that accepts start. Bit k (k=0 is the MSB) is consumed at edge E(k+1).
- match for bit k is visible in the cycle after E(k+1).
- done is high in the cycle after E(SEQ_W), which is E10 at the defaults. This gives a start-to-done latency of SEQ_W edges.
- The earliest next start is accepted at E(SEQ_W+2), when the FSM is in IDLE. If start is held high continuously, scans repeat every SEQ_W+2 cycles.
- match_count is already updated in the same cycle that match is visible.

## Configuration
- SEQ_DET_OVERLAP_EN defined: matches may overlap. The history and seen are kept after a hit.
- SEQ_DET_OVERLAP_EN undefined: non-overlapping detection. On a hit, seen is cleared to 0, so the next hit needs PAT_W fresh bits.

## Structure
- A package `seq_det_pkg` holds:
  - the state enum (IDLE, SCAN, DONE);
  - default constants SEQ_W=10, PAT_W=4, PATTERN=4'b1011, CNT_W=4.
- One sub-module, `seq_pattern_matcher`, is natural. It contains the history, seen and hit logic and the overlap macro handling. It takes a bit, a bit_valid and a clear input, and produces hit.
- The top level owns the FSM, shift register and counters.

## Test plan
- seq_in=10'b1011011011, with overlap enabled:
  - match after E4, E7 and E10;
  - match_count=3;
  - done in the cycle after E10.
- Same stimulus with the macro undefined:
  - match after E4 and E10 only;
  - match_count=2.
- seq_in=10'b0000000000 and seq_in=10'b1111111111: no match pulses; match_count=0; done after exactly 10 edges.
- start pulsed again at E3 with seq_in changed to 10'b1011000000:
  - ignored;
  - the scan result comes from the original data;
  - busy stays high E1..E10.
- rst asserted at E5 during a scan of 10'b1011011011:
  - the next cycle shows busy=0, match_count=0, bit_idx=0, IDLE;
  - done never pulses;
  - a new start then gives a clean result of 3 with overlap enabled.
- start held high with seq_in=10'b1011101100: scans repeat every 12 cycles, and each scan gives match_count=2 with overlap enabled.
